// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: default geometry, a constant clog2
// and a select-width macro usable in port declarations of sibling blocks.
`ifndef MUX_SEL_W
`define MUX_SEL_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package mux_pkg;

    localparam int DEFAULT_N_IN  = 8;
    localparam int DEFAULT_WIDTH = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux2_reg.sv
// One registered 2:1 node of the mux tree: data, valid and sideband are all
// steered by the same select so a node never mixes fields of two samples.
module mux2_reg #(
    parameter int WIDTH = 1,
    parameter int SB_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v0,
    input  logic             v1,
    input  logic [SB_W-1:0]  sb0,
    input  logic [SB_W-1:0]  sb1,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    output logic [SB_W-1:0]  q_sb
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic [SB_W-1:0]  sb_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            sb_reg    <= '0;
        end else if (en) begin
            data_reg  <= sel ? d1  : d0;
            valid_reg <= sel ? v1  : v0;
            sb_reg    <= sel ? sb1 : sb0;
        end
    end

    assign q_data  = data_reg;
    assign q_valid = valid_reg;
    assign q_sb    = sb_reg;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree with one register per level, a carried channel index
// and last flag, and an auto-scan mode that sweeps channels 0..N_IN-1.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int  N_IN   = DEFAULT_N_IN,
    parameter int  WIDTH  = DEFAULT_WIDTH,
    localparam int LEVELS = clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [LEVELS-1:0]     in_sel,
    input  logic                  in_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [LEVELS-1:0]     out_sel,
    output logic                  out_valid,
    output logic                  out_last
);

    // Sideband carries {last, full index}; bit k of the index steers level k.
    localparam int SB_W  = LEVELS + 1;
    localparam int NODES = 2 * N_IN;

    logic [LEVELS-1:0] scan_idx_reg;
    logic [LEVELS-1:0] sel_eff;
    logic              last_launch;

    // Heap-ordered tree: node 1 is the root, node n has children 2n and 2n+1,
    // channel i sits at leaf N_IN+i.
    logic [WIDTH-1:0]  node_data  [1:NODES-1];
    logic              node_valid [1:NODES-1];
    logic [SB_W-1:0]   node_sb    [1:NODES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx_reg <= '0;
        end else if (en) begin
            if (!mode) begin
                scan_idx_reg <= '0;
            end else if (in_valid) begin
                scan_idx_reg <= scan_idx_reg + LEVELS'(1);
            end
        end
    end

    assign sel_eff     = mode ? scan_idx_reg : in_sel;
    assign last_launch = mode && in_valid && (scan_idx_reg == LEVELS'(N_IN - 1));

    genvar gi, gj;

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_leaf
            assign node_data[N_IN + gi]  = in_data[gi*WIDTH +: WIDTH];
            assign node_valid[N_IN + gi] = in_valid;
            assign node_sb[N_IN + gi]    = {last_launch, sel_eff};
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            for (gj = 0; gj < (N_IN >> (gi + 1)); gj++) begin : g_node
                localparam int NODE = (N_IN >> (gi + 1)) + gj;

                mux2_reg #(
                    .WIDTH (WIDTH),
                    .SB_W  (SB_W)
                ) u_mux2 (
                    .clk     (clk),
                    .rst     (rst),
                    .en      (en),
                    .sel     (node_sb[2*NODE][gi]),
                    .d0      (node_data[2*NODE]),
                    .d1      (node_data[2*NODE + 1]),
                    .v0      (node_valid[2*NODE]),
                    .v1      (node_valid[2*NODE + 1]),
                    .sb0     (node_sb[2*NODE]),
                    .sb1     (node_sb[2*NODE + 1]),
                    .q_data  (node_data[NODE]),
                    .q_valid (node_valid[NODE]),
                    .q_sb    (node_sb[NODE])
                );
            end
        end
    endgenerate

    assign out_data  = node_data[1];
    assign out_valid = node_valid[1];
    assign out_sel   = node_sb[1][LEVELS-1:0];
    assign out_last  = node_sb[1][LEVELS];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: an 8x1-bit and a 16x8-bit instance share control
// and are scored against timestamped expected-sample queues.
module tb_mux_tree_pipe;

    localparam int NA = 8;
    localparam int WA = 1;
    localparam int LA = 3;
    localparam int NB = 16;
    localparam int WB = 8;
    localparam int LB = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic mode;
    logic in_valid;

    logic [NA*WA-1:0] a_in_data;
    logic [LA-1:0]    a_in_sel;
    logic [WA-1:0]    a_out_data;
    logic [LA-1:0]    a_out_sel;
    logic             a_out_valid;
    logic             a_out_last;

    logic [NB*WB-1:0] b_in_data;
    logic [LB-1:0]    b_in_sel;
    logic [WB-1:0]    b_out_data;
    logic [LB-1:0]    b_out_sel;
    logic             b_out_valid;
    logic             b_out_last;

    always #5 clk = ~clk;

    mux_tree_pipe #(.N_IN(NA), .WIDTH(WA)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_valid  (in_valid),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .out_valid (a_out_valid),
        .out_last  (a_out_last)
    );

    mux_tree_pipe #(.N_IN(NB), .WIDTH(WB)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_valid  (in_valid),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .out_valid (b_out_valid),
        .out_last  (b_out_last)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] sel;
        logic       last;
        int         due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total    = 0;
    int   bad      = 0;
    int   en_edges = 0;
    int   scan_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // One clock edge: update the scoreboard model, then sample the DUTs 1ns later.
    task automatic step();
        int         ia;
        int         ib;
        logic [7:0] da;
        logic [7:0] db;
        logic       va;
        logic       vb;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
            scan_cnt = 0;
        end else if (en) begin
            if (qa.size() > 0 && qa[0].due == en_edges) void'(qa.pop_front());
            if (qb.size() > 0 && qb[0].due == en_edges) void'(qb.pop_front());
            if (in_valid) begin
                ia = mode ? (scan_cnt % NA) : int'(a_in_sel);
                ib = mode ? (scan_cnt % NB) : int'(b_in_sel);
                da = 8'(a_in_data[ia*WA +: WA]);
                db = b_in_data[ib*WB +: WB];
                qa.push_back('{data: da, sel: 4'(ia), last: (mode && ia == NA - 1), due: en_edges + LA});
                qb.push_back('{data: db, sel: 4'(ib), last: (mode && ib == NB - 1), due: en_edges + LB});
            end
            if (!mode) scan_cnt = 0;
            else if (in_valid) scan_cnt++;
            en_edges++;
        end
        #1;
        va = (qa.size() > 0) && (qa[0].due == en_edges);
        vb = (qb.size() > 0) && (qb[0].due == en_edges);
        check("a_valid", 64'(a_out_valid), 64'(va));
        check("b_valid", 64'(b_out_valid), 64'(vb));
        if (va) begin
            check("a_data", 64'(a_out_data), 64'(qa[0].data[WA-1:0]));
            check("a_sel",  64'(a_out_sel),  64'(qa[0].sel[LA-1:0]));
            check("a_last", 64'(a_out_last), 64'(qa[0].last));
            $display("t=%0t a: data=%0h sel=%0d last=%0b", $time, a_out_data, a_out_sel, a_out_last);
        end else begin
            check("a_last_idle", 64'(a_out_last), 64'd0);
        end
        if (vb) begin
            check("b_data", 64'(b_out_data), 64'(qb[0].data));
            check("b_sel",  64'(b_out_sel),  64'(qb[0].sel));
            check("b_last", 64'(b_out_last), 64'(qb[0].last));
            $display("t=%0t b: data=%0h sel=%0d last=%0b", $time, b_out_data, b_out_sel, b_out_last);
        end else begin
            check("b_last_idle", 64'(b_out_last), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_data"},  64'(a_out_data),  64'd0);
        check({tag, "_a_sel"},   64'(a_out_sel),   64'd0);
        check({tag, "_a_valid"}, 64'(a_out_valid), 64'd0);
        check({tag, "_b_data"},  64'(b_out_data),  64'd0);
        check({tag, "_b_sel"},   64'(b_out_sel),   64'd0);
        check({tag, "_b_valid"}, 64'(b_out_valid), 64'd0);
    endtask

    task automatic load_ramp();
        for (int c = 0; c < NB; c++) b_in_data[c*WB +: WB] = 8'(8'hA0 + c);
        a_in_data = 8'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        a_in_data = '0;
        a_in_sel  = '0;
        b_in_data = '0;
        b_in_sel  = '0;

        // Reset, with en low: reset must still win.
        step();
        step();
        check_all_zero("reset");

        // Direct mode: one hot channel at a time, all others zero.
        rst = 1'b0;
        en  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            a_in_data = 8'(1 << (i % NA));
            a_in_sel  = 3'(i % NA);
            b_in_data = '0;
            b_in_data[i*WB +: WB] = 8'(8'hC0 + i);
            b_in_sel  = 4'(i);
            step();
        end

        // Direct mode: random data and selects.
        for (int i = 0; i < 8; i++) begin
            a_in_data = 8'($urandom);
            a_in_sel  = 3'($urandom_range(0, NA - 1));
            for (int c = 0; c < NB; c++) b_in_data[c*WB +: WB] = 8'($urandom);
            b_in_sel  = 4'($urandom_range(0, NB - 1));
            step();
        end

        // Switch to scan while direct samples are still in flight.
        mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            load_ramp();
            step();
        end

        // Stall mid-scan, then resume.
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_ramp();
            step();
        end

        // Reset with three samples in flight.
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        en  = 1'b0;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        en  = 1'b1;

        // Scan with alternating valid gaps.
        for (int i = 0; i < 24; i++) begin
            in_valid = ~i[0];
            load_ramp();
            step();
        end

        // Drain in direct mode with no new samples.
        mode     = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < LB + 2; i++) step();
        check("drain_a", 64'(qa.size()), 64'd0);
        check("drain_b", 64'(qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
